// File: rtl/cache_line_adapter.sv
// Line-granular refill/writeback sequencer between a data L1 and a word-wide
// memory port: optional dirty-victim writeback, then a full line fill.
module cache_line_adapter #(
    parameter int WORD_SIZE      = 32,
    parameter int ADDR_SIZE      = 32,
    parameter int WORDS_PER_LINE = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 access,
    input  logic [ADDR_SIZE-1:0] cpu_addr,
    input  logic                 cache_hit,
    input  logic                 cache_dirty,
    input  logic [ADDR_SIZE-1:0] victim_addr,
    input  logic [WORD_SIZE-1:0] cache_rdata,
    output logic [ADDR_SIZE-1:0] cache_addr,
    output logic [WORD_SIZE-1:0] cache_wdata,
    output logic                 we_cache,
    output logic                 word_mode,
    output logic                 stall,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    input  logic                 mem_ack
);

    localparam int CNT_W = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
    localparam int BSH   = $clog2(WORD_SIZE / 8);
    localparam int OFFB  = $clog2(WORDS_PER_LINE) + BSH;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WB,
        S_FILL,
        S_DONE
    } state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [ADDR_SIZE-1:0] r_miss_base;
    logic [ADDR_SIZE-1:0] r_victim_base;

    logic [ADDR_SIZE-1:0] w_off;
    logic [ADDR_SIZE-1:0] w_line_mask;
    logic [ADDR_SIZE-1:0] w_vaddr;
    logic [ADDR_SIZE-1:0] w_maddr;
    logic                 w_miss;

    assign w_off       = ADDR_SIZE'(r_cnt) << BSH;
    assign w_line_mask = ~((ADDR_SIZE'(1) << OFFB) - ADDR_SIZE'(1));
    assign w_vaddr     = r_victim_base + w_off;
    assign w_maddr     = r_miss_base + w_off;
    assign w_miss      = access & ~cache_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_miss_base   <= '0;
            r_victim_base <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_miss) begin
                        r_miss_base   <= cpu_addr & w_line_mask;
                        r_victim_base <= victim_addr;
                        r_cnt         <= '0;
                        r_state       <= cache_dirty ? S_WB : S_FILL;
                    end
                end
                S_WB: begin
                    if (mem_ack) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == LAST) begin
                            r_cnt   <= '0;
                            r_state <= S_FILL;
                        end
                    end
                end
                S_FILL: begin
                    if (mem_ack) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == LAST) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Outputs decode from the registered state; reset gates the strobes
    // immediately, even while the state flops are being cleared.
    always_comb begin
        cache_addr  = cpu_addr;
        cache_wdata = mem_rdata;
        we_cache    = 1'b0;
        word_mode   = 1'b0;
        stall       = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        unique case (r_state)
            S_IDLE: begin
                stall = w_miss;
            end
            S_WB: begin
                mem_req    = 1'b1;
                mem_we     = 1'b1;
                mem_addr   = w_vaddr;
                mem_wdata  = cache_rdata;
                cache_addr = w_vaddr;
                stall      = 1'b1;
                word_mode  = 1'b1;
            end
            S_FILL: begin
                mem_req    = 1'b1;
                mem_addr   = w_maddr;
                cache_addr = w_maddr;
                we_cache   = mem_ack;
                stall      = 1'b1;
                word_mode  = 1'b1;
            end
            S_DONE: begin
                stall = 1'b1;
            end
            default: ;
        endcase
        if (!reset) begin
            stall     = 1'b0;
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            we_cache  = 1'b0;
            word_mode = 1'b0;
        end
    end

endmodule
